// File: rtl/csr_file.sv
// LoongArch CSR file: control/status registers, exception/ertn state update,
// interrupt sampling and the constant timer, with combinational read port.
module csr_file #(
    parameter logic [31:0] COREID = 32'h0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        csr_re,
    input  logic [13:0] csr_num,
    output logic [31:0] csr_rvalue,
    input  logic        csr_we,
    input  logic [31:0] csr_wmask,
    input  logic [31:0] csr_wvalue,
    input  logic        wb_ex,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_vaddr,
    input  logic        ertn_flush,
    input  logic [7:0]  hw_int_in,
    input  logic        ipi_int_in,
    output logic [31:0] ex_entry,
    output logic [31:0] ertn_entry,
    output logic        has_int
);

    localparam logic [13:0] ADDR_CRMD   = 14'h000;
    localparam logic [13:0] ADDR_PRMD   = 14'h001;
    localparam logic [13:0] ADDR_ECFG   = 14'h004;
    localparam logic [13:0] ADDR_ESTAT  = 14'h005;
    localparam logic [13:0] ADDR_ERA    = 14'h006;
    localparam logic [13:0] ADDR_BADV   = 14'h007;
    localparam logic [13:0] ADDR_EENTRY = 14'h00C;
    localparam logic [13:0] ADDR_SAVE0  = 14'h030;
    localparam logic [13:0] ADDR_SAVE1  = 14'h031;
    localparam logic [13:0] ADDR_SAVE2  = 14'h032;
    localparam logic [13:0] ADDR_SAVE3  = 14'h033;
    localparam logic [13:0] ADDR_TID    = 14'h040;
    localparam logic [13:0] ADDR_TCFG   = 14'h041;
    localparam logic [13:0] ADDR_TVAL   = 14'h042;
    localparam logic [13:0] ADDR_TICLR  = 14'h044;

    localparam logic [5:0]  ECODE_ADE   = 6'h08;
    localparam logic [5:0]  ECODE_ALE   = 6'h09;
    localparam logic [12:0] LIE_MASK    = 13'h1BFF;

    logic [8:0]  crmd_q, crmd_d;
    logic [2:0]  prmd_q, prmd_d;
    logic [12:0] ecfg_q, ecfg_d;
    logic [12:0] estat_is_q, estat_is_d;
    logic [5:0]  estat_ecode_q, estat_ecode_d;
    logic [8:0]  estat_esub_q, estat_esub_d;
    logic [31:0] era_q, era_d;
    logic [31:0] badv_q, badv_d;
    logic [25:0] eentry_q, eentry_d;
    logic [31:0] save_q [4];
    logic [31:0] save_d [4];
    logic [31:0] tid_q, tid_d;
    logic [31:0] tcfg_q, tcfg_d;
    logic [31:0] tval_q, tval_d;

    logic        wr_en;
    logic [31:0] wr_merge;
    logic        timer_fire;
    logic        ticlr_hit;
    logic [31:0] rdata;

    // Pipeline writes lose to exception/ertn commits in the same cycle.
    assign wr_en    = csr_we & ~wb_ex & ~ertn_flush;
    assign wr_merge = csr_wvalue & csr_wmask;

    always_comb begin
        crmd_d        = crmd_q;
        prmd_d        = prmd_q;
        ecfg_d        = ecfg_q;
        estat_is_d    = estat_is_q;
        estat_ecode_d = estat_ecode_q;
        estat_esub_d  = estat_esub_q;
        era_d         = era_q;
        badv_d        = badv_q;
        eentry_d      = eentry_q;
        save_d        = save_q;
        tid_d         = tid_q;
        tcfg_d        = tcfg_q;
        tval_d        = tval_q;
        timer_fire    = 1'b0;
        ticlr_hit     = 1'b0;

        if (wr_en) begin
            case (csr_num)
                ADDR_CRMD:   crmd_d = (crmd_q & ~csr_wmask[8:0]) | wr_merge[8:0];
                ADDR_PRMD:   prmd_d = (prmd_q & ~csr_wmask[2:0]) | wr_merge[2:0];
                ADDR_ECFG:   ecfg_d = (ecfg_q & ~(csr_wmask[12:0] & LIE_MASK))
                                    | (wr_merge[12:0] & LIE_MASK);
                ADDR_ESTAT:  estat_is_d[1:0] = (estat_is_q[1:0] & ~csr_wmask[1:0]) | wr_merge[1:0];
                ADDR_ERA:    era_d = (era_q & ~csr_wmask) | wr_merge;
                ADDR_BADV:   badv_d = (badv_q & ~csr_wmask) | wr_merge;
                ADDR_EENTRY: eentry_d = (eentry_q & ~csr_wmask[31:6]) | wr_merge[31:6];
                ADDR_SAVE0:  save_d[0] = (save_q[0] & ~csr_wmask) | wr_merge;
                ADDR_SAVE1:  save_d[1] = (save_q[1] & ~csr_wmask) | wr_merge;
                ADDR_SAVE2:  save_d[2] = (save_q[2] & ~csr_wmask) | wr_merge;
                ADDR_SAVE3:  save_d[3] = (save_q[3] & ~csr_wmask) | wr_merge;
                ADDR_TID:    tid_d = (tid_q & ~csr_wmask) | wr_merge;
                ADDR_TCFG:   tcfg_d = (tcfg_q & ~csr_wmask) | wr_merge;
                ADDR_TICLR:  ticlr_hit = wr_merge[0];
                default: ;
            endcase
        end

        if (wb_ex) begin
            prmd_d        = crmd_q[2:0];
            crmd_d[2:0]   = 3'b000;
            estat_ecode_d = wb_ecode;
            estat_esub_d  = wb_esubcode;
            era_d         = wb_pc;
            if (wb_ecode == ECODE_ADE) begin
                badv_d = wb_pc;
            end else if (wb_ecode == ECODE_ALE) begin
                badv_d = wb_vaddr;
            end
        end else if (ertn_flush) begin
            crmd_d[2:0] = prmd_q;
        end

        // A TCFG write that enables the timer reloads it instead of counting.
        if (wr_en && csr_num == ADDR_TCFG && tcfg_d[0]) begin
            tval_d = {tcfg_d[31:2], 2'b00};
        end else if (tcfg_q[0] && tval_q != 32'hFFFF_FFFF) begin
            if (tval_q == 32'd0) begin
                timer_fire = 1'b1;
                tval_d     = tcfg_q[1] ? {tcfg_q[31:2], 2'b00} : 32'hFFFF_FFFF;
            end else begin
                tval_d = tval_q - 32'd1;
            end
        end

        estat_is_d[9:2] = hw_int_in;
        estat_is_d[12]  = ipi_int_in;
        if (timer_fire) begin
            estat_is_d[11] = 1'b1;
        end else if (ticlr_hit) begin
            estat_is_d[11] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            crmd_q        <= 9'h008;
            prmd_q        <= '0;
            ecfg_q        <= '0;
            estat_is_q    <= '0;
            estat_ecode_q <= '0;
            estat_esub_q  <= '0;
            era_q         <= '0;
            badv_q        <= '0;
            eentry_q      <= '0;
            for (int i = 0; i < 4; i++) begin
                save_q[i] <= '0;
            end
            tid_q         <= COREID;
            tcfg_q        <= '0;
            tval_q        <= '0;
        end else begin
            crmd_q        <= crmd_d;
            prmd_q        <= prmd_d;
            ecfg_q        <= ecfg_d;
            estat_is_q    <= estat_is_d;
            estat_ecode_q <= estat_ecode_d;
            estat_esub_q  <= estat_esub_d;
            era_q         <= era_d;
            badv_q        <= badv_d;
            eentry_q      <= eentry_d;
            save_q        <= save_d;
            tid_q         <= tid_d;
            tcfg_q        <= tcfg_d;
            tval_q        <= tval_d;
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (csr_num)
            ADDR_CRMD:   rdata = {23'd0, crmd_q};
            ADDR_PRMD:   rdata = {29'd0, prmd_q};
            ADDR_ECFG:   rdata = {19'd0, ecfg_q};
            ADDR_ESTAT:  rdata = {1'b0, estat_esub_q, estat_ecode_q, 3'b000, estat_is_q};
            ADDR_ERA:    rdata = era_q;
            ADDR_BADV:   rdata = badv_q;
            ADDR_EENTRY: rdata = {eentry_q, 6'd0};
            ADDR_SAVE0:  rdata = save_q[0];
            ADDR_SAVE1:  rdata = save_q[1];
            ADDR_SAVE2:  rdata = save_q[2];
            ADDR_SAVE3:  rdata = save_q[3];
            ADDR_TID:    rdata = tid_q;
            ADDR_TCFG:   rdata = tcfg_q;
            ADDR_TVAL:   rdata = tval_q;
            default:     rdata = 32'd0;
        endcase
    end

    assign csr_rvalue = csr_re ? rdata : 32'd0;
    assign ex_entry   = {eentry_q, 6'd0};
    assign ertn_entry = era_q;
    assign has_int    = crmd_q[2] & |(estat_is_q & ecfg_q);

endmodule
